// File: rtl/reg_sweeper_if.sv
// reg_sweeper_if: control/target bundle between a sweep requester and reg_sweeper.
// master drives go/direction; slave (the sweeper) drives the register-file side.
interface reg_sweeper_if #(
    parameter int REG_W = 5
);
    logic             go;
    logic             direction;
    logic             done;
    logic             busy;
    logic             wr_en;
    logic [REG_W-1:0] regnum;

    modport master (
        output go, direction,
        input  done, busy, wr_en, regnum
    );

    modport slave (
        input  go, direction,
        output done, busy, wr_en, regnum
    );
endinterface

// File: rtl/reg_sweeper.sv
// reg_sweeper: on go, writes START, then walks LEN registers up/down (mod 2^REG_W).
// Define REG_SWEEPER_SKIP_ZERO_EN to skip register 0 during the walk.
module reg_sweeper #(
    parameter int REG_W = 5,
    parameter int START = 8,
    parameter int LEN   = 4
) (
    input logic          clock,
    input logic          reset,
    reg_sweeper_if.slave bus
);
    localparam int KW = $clog2(LEN + 1);
`ifdef REG_SWEEPER_SKIP_ZERO_EN
    localparam int OW = REG_W + 1;
`else
    localparam int OW = REG_W;
`endif
    localparam logic [REG_W-1:0] BASE = REG_W'(START);
    localparam logic [KW-1:0]    LAST = KW'(LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [OW-1:0]    off;
    logic             dir_q;
    logic             done_q;
    logic             busy_q;
    logic             wr_q;
    logic [REG_W-1:0] reg_q;

    logic             up_nxt;
    logic [OW-1:0]    off_base;
    logic [OW-1:0]    off_nxt;

    function automatic logic [REG_W-1:0] target(
        input logic [OW-1:0] o,
        input logic          up
    );
        logic [REG_W-1:0] t;
        t = o[REG_W-1:0];
        return up ? BASE + t : BASE - t;
    endfunction

    // Offset of the next sweep step; the Start cycle seeds it from zero
    // with the live direction, later steps reuse the latched one.
    always_comb begin
        up_nxt   = (state == S_START) ? bus.direction : dir_q;
        off_base = (state == S_START) ? '0 : off;
        off_nxt  = off_base + OW'(1);
`ifdef REG_SWEEPER_SKIP_ZERO_EN
        if (target(off_nxt, up_nxt) == '0)
            off_nxt = off_base + OW'(2);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            k      <= '0;
            off    <= '0;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            wr_q   <= 1'b0;
            reg_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.go) begin
                        state  <= S_START;
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                        wr_q   <= 1'b1;
                        reg_q  <= BASE;
                    end
                end
                S_START: begin
                    if (!bus.go) begin
                        state <= S_SWEEP;
                        k     <= KW'(1);
                        dir_q <= bus.direction;
                        off   <= off_nxt;
                        reg_q <= target(off_nxt, up_nxt);
                    end
                end
                S_SWEEP: begin
                    if (k == LAST) begin
                        state  <= S_DONE;
                        k      <= '0;
                        off    <= '0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        wr_q   <= 1'b0;
                        reg_q  <= '0;
                    end else begin
                        k     <= k + KW'(1);
                        off   <= off_nxt;
                        reg_q <= target(off_nxt, up_nxt);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.wr_en  = wr_q;
    assign bus.regnum = reg_q;
endmodule

// File: tb/tb_reg_sweeper.sv
// tb_reg_sweeper: three sweeper configs share one random/directed stimulus;
// a phase-level reference model feeds a scoreboard checked every cycle.
module tb_reg_sweeper;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic go    = 1'b0;
    logic dir   = 1'b0;

    always #5 clock = ~clock;

    reg_sweeper_if #(.REG_W(5)) i0 ();
    reg_sweeper_if #(.REG_W(5)) i1 ();
    reg_sweeper_if #(.REG_W(5)) i2 ();

    assign i0.go = go;
    assign i1.go = go;
    assign i2.go = go;
    assign i0.direction = dir;
    assign i1.direction = dir;
    assign i2.direction = dir;

    reg_sweeper #(.REG_W(5), .START(8), .LEN(4)) u0 (
        .clock(clock), .reset(reset), .bus(i0.slave));
    reg_sweeper #(.REG_W(5), .START(30), .LEN(4)) u1 (
        .clock(clock), .reset(reset), .bus(i1.slave));
    reg_sweeper #(.REG_W(5), .START(8), .LEN(1)) u2 (
        .clock(clock), .reset(reset), .bus(i2.slave));

    int m_start [3] = '{8, 30, 8};
    int m_len   [3] = '{4, 4, 1};
    // ph: 0 idle, 1 start, 2 sweeping (idx = step), 3 done
    int ph  [3] = '{0, 0, 0};
    int idx [3] = '{0, 0, 0};
    bit dq  [3] = '{0, 0, 0};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [23:0] sb[$];

    function automatic int nth(int s, int i, bit up);
        int o   = 0;
        int cnt = -1;
        int r   = 0;
        while (cnt < i) begin
            o++;
            r = up ? (s + o) % 32 : ((s - o) % 32 + 32) % 32;
`ifdef REG_SWEEPER_SKIP_ZERO_EN
            if (r == 0) continue;
`endif
            cnt++;
        end
        return r;
    endfunction

    function automatic logic [7:0] expect_of(int n);
        logic [4:0] r;
        case (ph[n])
            1: return {3'b011, 5'(m_start[n])};
            2: begin
                r = 5'(nth(m_start[n], idx[n], dq[n]));
                return {3'b011, r};
            end
            3: return 8'b1000_0000;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(int n);
        if (reset) begin
            ph[n] = 0;
        end else begin
            case (ph[n])
                0, 3: if (go) ph[n] = 1;
                1: if (!go) begin
                    dq[n]  = dir;
                    idx[n] = 0;
                    ph[n]  = 2;
                end
                2: if (idx[n] == m_len[n] - 1) ph[n] = 3;
                   else idx[n]++;
                default: ph[n] = 0;
            endcase
        end
    endtask

    task automatic cycle(logic r, logic g, logic d);
        reset = r;
        go    = g;
        dir   = d;
        @(posedge clock);
        for (int n = 0; n < 3; n++) model_step(n);
        sb.push_back({expect_of(2), expect_of(1), expect_of(0)});
        @(negedge clock);
    endtask

    function automatic logic [7:0] act(int n);
        case (n)
            0: return {i0.done, i0.busy, i0.wr_en, i0.regnum};
            1: return {i1.done, i1.busy, i1.wr_en, i1.regnum};
            default: return {i2.done, i2.busy, i2.wr_en, i2.regnum};
        endcase
    endfunction

    initial begin : monitor
        logic [23:0] e;
        logic [7:0]  a;
        logic [7:0]  x;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cyc++;
                for (int n = 0; n < 3; n++) begin
                    a = act(n);
                    x = e[n*8 +: 8];
                    checks++;
                    if (a !== x) begin
                        errors++;
                        $display("FAIL dut%0d cyc%0d done/busy/wr/reg got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                                 n, cyc, a[7], a[6], a[5], a[4:0],
                                 x[7], x[6], x[5], x[4:0]);
                    end
                end
            end
        end
    end

    initial begin : stim
        cycle(1, 0, 0);
        cycle(1, 1, 1);
        cycle(0, 0, 0);
        // ascending, go high two cycles
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        repeat (7) cycle(0, 0, 1);
        // descending single pulse, direction toggled mid-sweep
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1'(i));
        // reset on second sweep cycle, then fresh run
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        repeat (7) cycle(0, 0, 1);
        // go pulsed mid-sweep, then go pulsed in done
        cycle(0, 1, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 1);
        cycle(0, 1, 1);
        cycle(0, 0, 0);
        repeat (6) cycle(0, 0, 0);
        // go held through done
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        repeat (6) cycle(0, 1, 1);
        cycle(0, 0, 1);
        repeat (6) cycle(0, 0, 1);
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)));
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
